usb_reg_responder: RTL and testbench
====================================

// Module: usb_reg_responder
// PURPOSE
// - Target-side responder for the CW305 parallel USB register bus (USB_Data/Addr/nRD/nWE/nCS), synchronous to usb_clk.
// - Decodes address into {block, register, subbyte}, emits one-cycle write/read strobes to register blocks (main, trace, ...).
// - Muxes per-block read data onto the bidirectional data bus and controls the tri-state enable.
// - Sits between the top-level pads and all register blocks. Replaces ad-hoc per-block decode.
// PARAMETERS
// - pADDR_WIDTH     21  USB address bus width
// - pBYTECNT_SIZE   7   subbyte field width, usb_addr[pBYTECNT_SIZE-1:0]
// - pREG_BITS       5   register field width, usb_addr[pBYTECNT_SIZE +: pREG_BITS]
// - pBLOCK_BITS     3   block-select width, next field up; remaining upper address bits ignored
// PORTS
// - usb_clk          in   1        bus clock; all logic on rising edge
// - resetn           in   1        asynchronous, active-low reset
// - usb_addr         in   pADDR_WIDTH  host address
// - usb_din          in   8        data from pad (host write)
// - usb_dout         out  8        data to pad (host read)
// - usb_doe          out  1        pad output enable, 1 = drive usb_dout
// - usb_rdn          in   1        read strobe, active low
// - usb_wrn          in   1        write strobe, active low
// - usb_cen          in   1        chip enable, active low
// - reg_block        out  pBLOCK_BITS  registered block select
// - reg_address      out  pREG_BITS    registered register address
// - reg_bytecnt      out  pBYTECNT_SIZE registered subbyte index
// - reg_datao        out  8        registered write data
// - reg_write        out  1        one-cycle write strobe
// - reg_read         out  1        one-cycle read strobe (FIFO-pop side effects key off this)
// - reg_datai_flat   in   8*2**pBLOCK_BITS  per-block read data, block n at [8n +: 8], combinational from reg_address/reg_bytecnt
// - bus_err          out  1        sticky: rdn and wrn both low while cen low
// BEHAVIOUR
// - Reset: all outputs 0, usb_doe=0, bus_err=0, edge detector treats cen as high. Async assert, sync deassert handled upstream.
// - Address fields registered every cycle from usb_addr. Host holds address >=1 cycle before cen falls, so fields are stable at the strobe.
// - cen_q = previous sampled usb_cen. Access start = (usb_cen==0 && cen_q==1). cen held low N cycles yields exactly one access.
// - Write: at access start with wrn=0, rdn=1: reg_datao<=usb_din and reg_write=1 for exactly one cycle, registered.
//   Sequence: addr/data/wrn low, then cen low 1 cycle. reg_write is high in the cycle after the edge that samples cen low.
// - Read: usb_doe<=1 on any edge that samples rdn=0, wrn=1. usb_doe<=0 on first edge that samples rdn=1.
// - Read data: at access start with rdn=0, usb_dout<=reg_datai_flat[8*reg_block +: 8] and reg_read=1 for one cycle.
//   usb_dout is valid immediately after the same edge that samples cen low; host samples 1 ns later, so zero-cycle latency from that edge is required.
// - usb_dout holds its value until the next read access start.
// - Simultaneous rdn=0 and wrn=0 at access start: no strobe, usb_doe stays 0, bus_err<=1. Only reset clears bus_err.
// - cen low with rdn=wrn=1: no strobe, no error.
// - Back-to-back accesses (cen high >=1 cycle between them): each gets its own strobe. No minimum gap beyond 1 cycle.
// - Reset mid-access: strobes and usb_doe drop immediately. After release, cen already low is NOT an access start (cen_q resets high only if usb_cen was high, i.e. resets to 1 then needs a real falling edge).
// - Block index beyond populated blocks reads 8'h00 (unused slices tied 0 at instantiation).
// STRUCTURE
// - Shared package/defines: field widths, block IDs (MAIN_REG_SELECT, TRACE_REG_SELECT), access-type encoding.
// - Single flat module, no sub-modules. The read mux is a generate-indexed part-select.
// - Top level owns the tri-state: USB_Data = usb_doe ? usb_dout : 8'bz.
// TESTING
// - Write block 1 reg 5 byte 2 data 8'hA5 -> one reg_write pulse; reg_block=1, reg_address=5, reg_bytecnt=2, reg_datao=A5.
// - Read block 0 with datai=8'h3C -> usb_dout=3C valid 1 ns after the edge sampling cen low; one reg_read pulse; usb_doe falls the edge after rdn rises.
// - Hold cen low 5 cycles during a write -> exactly one reg_write.
// - 4-byte read_word loop, subbytes 0..3 -> 4 reg_read pulses, bytecnt 0,1,2,3, bytes assembled LSB-first.
// - rdn=wrn=0 with cen low -> no strobes, usb_doe=0, bus_err=1 until resetn pulse.
// - Assert resetn low mid-read -> usb_doe=0 and usb_dout=0 asynchronously; holding cen low after release produces no strobe.

Source files
------------

// File: rtl/usb_reg_responder_pkg.sv
// Shared field widths, block IDs and access-type encoding for the CW305 USB register bus.
package usb_reg_responder_pkg;

    localparam int ADDR_WIDTH   = 21;
    localparam int BYTECNT_SIZE = 7;
    localparam int REG_BITS     = 5;
    localparam int BLOCK_BITS   = 3;

    localparam logic [BLOCK_BITS-1:0] MAIN_REG_SELECT  = 3'd0;
    localparam logic [BLOCK_BITS-1:0] TRACE_REG_SELECT = 3'd1;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'b00,
        ACC_READ  = 2'b01,
        ACC_WRITE = 2'b10,
        ACC_ERR   = 2'b11
    } access_e;

    // Both strobes low at once is a host protocol violation, not a read or a write.
    function automatic access_e decode_access(input logic rdn, input logic wrn);
        access_e acc;
        case ({rdn, wrn})
            2'b01:   acc = ACC_READ;
            2'b10:   acc = ACC_WRITE;
            2'b00:   acc = ACC_ERR;
            default: acc = ACC_NONE;
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/usb_reg_responder_if.sv
// Pad-side view of the CW305 parallel USB bus (address, data, strobes, output enable).
interface usb_reg_responder_if
    import usb_reg_responder_pkg::*;
#(
    parameter int pADDR_WIDTH = ADDR_WIDTH
) ();

    logic [pADDR_WIDTH-1:0] usb_addr;
    logic [7:0]             usb_din;
    logic [7:0]             usb_dout;
    logic                   usb_doe;
    logic                   usb_rdn;
    logic                   usb_wrn;
    logic                   usb_cen;

    modport master (
        output usb_addr, usb_din, usb_rdn, usb_wrn, usb_cen,
        input  usb_dout, usb_doe
    );

    modport slave (
        input  usb_addr, usb_din, usb_rdn, usb_wrn, usb_cen,
        output usb_dout, usb_doe
    );

endinterface

// File: rtl/usb_reg_responder.sv
// Target-side responder: decodes the USB register bus into one-cycle strobes for the
// register blocks and returns the selected block's read byte with zero-cycle latency.
module usb_reg_responder
    import usb_reg_responder_pkg::*;
#(
    parameter int pADDR_WIDTH   = ADDR_WIDTH,
    parameter int pBYTECNT_SIZE = BYTECNT_SIZE,
    parameter int pREG_BITS     = REG_BITS,
    parameter int pBLOCK_BITS   = BLOCK_BITS
) (
    input  logic                         usb_clk,
    input  logic                         resetn,
    usb_reg_responder_if.slave           usb,
    output logic [pBLOCK_BITS-1:0]       reg_block,
    output logic [pREG_BITS-1:0]         reg_address,
    output logic [pBYTECNT_SIZE-1:0]     reg_bytecnt,
    output logic [7:0]                   reg_datao,
    output logic                         reg_write,
    output logic                         reg_read,
    input  logic [8*2**pBLOCK_BITS-1:0]  reg_datai_flat,
    output logic                         bus_err
);

    localparam int NUM_BLOCKS = 2**pBLOCK_BITS;
    localparam int FIELD_BITS = pBYTECNT_SIZE + pREG_BITS + pBLOCK_BITS;

    logic                     cen_q,     cen_d;
    logic                     armed_q,   armed_d;
    logic [pBLOCK_BITS-1:0]   block_q,   block_d;
    logic [pREG_BITS-1:0]     address_q, address_d;
    logic [pBYTECNT_SIZE-1:0] bytecnt_q, bytecnt_d;
    logic [7:0]               datao_q,   datao_d;
    logic                     write_q,   write_d;
    logic                     read_q,    read_d;
    logic [7:0]               dout_q,    dout_d;
    logic                     doe_q,     doe_d;
    logic                     bus_err_q, bus_err_d;

    access_e access;
    logic    acc_start;
    logic    addr_unused;

    logic [7:0] blk_data [NUM_BLOCKS];

    for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_blk_slice
        assign blk_data[g] = reg_datai_flat[8*g +: 8];
    end

    assign addr_unused = ^usb.usb_addr[pADDR_WIDTH-1:FIELD_BITS];

    assign access = decode_access(usb.usb_rdn, usb.usb_wrn);
    // armed_q blocks a start until cen has been seen high after reset, so a host
    // still holding cen low across reset release never triggers a spurious access.
    assign acc_start = !usb.usb_cen && cen_q && armed_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cen_d     = usb.usb_cen;
        armed_d   = armed_q | usb.usb_cen;
        block_d   = usb.usb_addr[pBYTECNT_SIZE+pREG_BITS +: pBLOCK_BITS];
        address_d = usb.usb_addr[pBYTECNT_SIZE +: pREG_BITS];
        bytecnt_d = usb.usb_addr[pBYTECNT_SIZE-1:0];
        datao_d   = datao_q;
        dout_d    = dout_q;
        write_d   = 1'b0;
        read_d    = 1'b0;
        doe_d     = (access == ACC_READ);
        bus_err_d = bus_err_q;

        if (acc_start) begin
            case (access)
                ACC_WRITE: begin
                    datao_d = usb.usb_din;
                    write_d = 1'b1;
                end
                ACC_READ: begin
                    // Address fields were registered at least one edge earlier, so the
                    // block's combinational read data is already settled here.
                    dout_d = blk_data[block_q];
                    read_d = 1'b1;
                end
                ACC_ERR:  bus_err_d = 1'b1;
                default:  ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge usb_clk or negedge resetn) begin
        if (!resetn) begin
            cen_q     <= 1'b1;
            armed_q   <= 1'b0;
            block_q   <= '0;
            address_q <= '0;
            bytecnt_q <= '0;
            datao_q   <= '0;
            write_q   <= 1'b0;
            read_q    <= 1'b0;
            dout_q    <= '0;
            doe_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            cen_q     <= cen_d;
            armed_q   <= armed_d;
            block_q   <= block_d;
            address_q <= address_d;
            bytecnt_q <= bytecnt_d;
            datao_q   <= datao_d;
            write_q   <= write_d;
            read_q    <= read_d;
            dout_q    <= dout_d;
            doe_q     <= doe_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign reg_block    = block_q;
    assign reg_address  = address_q;
    assign reg_bytecnt  = bytecnt_q;
    assign reg_datao    = datao_q;
    assign reg_write    = write_q;
    assign reg_read     = read_q;
    assign bus_err      = bus_err_q;
    assign usb.usb_dout = dout_q;
    assign usb.usb_doe  = doe_q;

endmodule

// File: tb/tb_usb_reg_responder.sv
// Scoreboard bench for usb_reg_responder: stimulus queues expected strobes, a monitor
// pops and checks them whenever reg_write or reg_read pulses.
module tb_usb_reg_responder;
    import usb_reg_responder_pkg::*;

    typedef struct {
        logic       is_write;
        logic [2:0] blk;
        logic [4:0] reg_a;
        logic [6:0] bcnt;
        logic [7:0] data;
    } exp_t;

    logic        usb_clk;
    logic        resetn;
    logic [2:0]  reg_block;
    logic [4:0]  reg_address;
    logic [6:0]  reg_bytecnt;
    logic [7:0]  reg_datao;
    logic        reg_write;
    logic        reg_read;
    logic [63:0] reg_datai_flat;
    logic        bus_err;
    logic [7:0]  blk0_val;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int rd_cnt  = 0;
    exp_t exp_q[$];

    usb_reg_responder_if bus ();

    usb_reg_responder dut (
        .usb_clk        (usb_clk),
        .resetn         (resetn),
        .usb            (bus),
        .reg_block      (reg_block),
        .reg_address    (reg_address),
        .reg_bytecnt    (reg_bytecnt),
        .reg_datao      (reg_datao),
        .reg_write      (reg_write),
        .reg_read       (reg_read),
        .reg_datai_flat (reg_datai_flat),
        .bus_err        (bus_err)
    );

    initial usb_clk = 1'b0;
    always #5 usb_clk = ~usb_clk;

    // Register-block model: block 0 constant, block 1 constant, block 2 address-dependent, rest tied 0.
    always_comb begin
        reg_datai_flat        = '0;
        reg_datai_flat[7:0]   = blk0_val;
        reg_datai_flat[15:8]  = 8'h5A;
        reg_datai_flat[23:16] = {reg_bytecnt[3:0], 4'h0} + {3'b000, reg_address} + 8'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] mk_addr(input logic [2:0] blk, input logic [4:0] r, input logic [6:0] b);
        return {6'b0, blk, r, b};
    endfunction

    // Monitor: one check per strobe, compared against the oldest queued expectation.
    always @(posedge usb_clk) begin
        #1;
        if (resetn && (reg_write || reg_read)) begin
            if (reg_write) wr_cnt++;
            if (reg_read)  rd_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {30'b0, reg_write, reg_read}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_kind", {30'b0, reg_write, reg_read}, e.is_write ? 32'h2 : 32'h1);
                check("reg_block",   {29'b0, reg_block},   {29'b0, e.blk});
                check("reg_address", {27'b0, reg_address}, {27'b0, e.reg_a});
                check("reg_bytecnt", {25'b0, reg_bytecnt}, {25'b0, e.bcnt});
                if (e.is_write) begin
                    check("reg_datao", {24'b0, reg_datao}, {24'b0, e.data});
                end else begin
                    check("usb_dout", {24'b0, bus.usb_dout}, {24'b0, e.data});
                    check("usb_doe_on_read", {31'b0, bus.usb_doe}, 32'h1);
                end
            end
        end
    end

    task automatic do_write(input logic [2:0] blk, input logic [4:0] r, input logic [6:0] b,
                            input logic [7:0] d, input int hold);
        exp_q.push_back('{is_write: 1'b1, blk: blk, reg_a: r, bcnt: b, data: d});
        @(negedge usb_clk);
        bus.usb_addr = mk_addr(blk, r, b);
        bus.usb_din  = d;
        bus.usb_wrn  = 1'b0;
        bus.usb_rdn  = 1'b1;
        @(negedge usb_clk);
        bus.usb_cen = 1'b0;
        repeat (hold) @(negedge usb_clk);
        bus.usb_cen = 1'b1;
        bus.usb_wrn = 1'b1;
    endtask

    task automatic do_read(input logic [2:0] blk, input logic [4:0] r, input logic [6:0] b,
                           input logic [7:0] d);
        exp_q.push_back('{is_write: 1'b0, blk: blk, reg_a: r, bcnt: b, data: d});
        @(negedge usb_clk);
        bus.usb_addr = mk_addr(blk, r, b);
        bus.usb_rdn  = 1'b0;
        bus.usb_wrn  = 1'b1;
        @(negedge usb_clk);
        bus.usb_cen = 1'b0;
        @(negedge usb_clk);
        bus.usb_cen = 1'b1;
        check("doe_while_rdn_low", {31'b0, bus.usb_doe}, 32'h1);
        bus.usb_rdn = 1'b1;
        @(negedge usb_clk);
        check("doe_after_rdn_high", {31'b0, bus.usb_doe}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int r0;
        logic [31:0] word;

        blk0_val     = 8'h3C;
        resetn       = 1'b0;
        bus.usb_addr = '0;
        bus.usb_din  = '0;
        bus.usb_rdn  = 1'b1;
        bus.usb_wrn  = 1'b1;
        bus.usb_cen  = 1'b1;
        repeat (3) @(negedge usb_clk);
        check("rst_reg_write", {31'b0, reg_write},    32'h0);
        check("rst_reg_read",  {31'b0, reg_read},     32'h0);
        check("rst_doe",       {31'b0, bus.usb_doe},  32'h0);
        check("rst_dout",      {24'b0, bus.usb_dout}, 32'h0);
        check("rst_bus_err",   {31'b0, bus_err},      32'h0);
        check("rst_datao",     {24'b0, reg_datao},    32'h0);
        resetn = 1'b1;
        repeat (2) @(negedge usb_clk);

        // Basic write and read.
        do_write(3'd1, 5'd5, 7'd2, 8'hA5, 1);
        do_read(3'd0, 5'd0, 7'd0, 8'h3C);

        // cen held low for five cycles produces a single write strobe.
        w0 = wr_cnt;
        do_write(3'd2, 5'd9, 7'd1, 8'h7E, 5);
        @(negedge usb_clk);
        check("hold5_write_count", wr_cnt - w0, 32'd1);
        check("dout_holds", {24'b0, bus.usb_dout}, 32'h3C);

        // 4-byte word read, LSB first.
        r0 = rd_cnt;
        word = '0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] eb;
            eb = 8'h04 + 8'h10 * i[7:0];
            do_read(3'd2, 5'd3, i[6:0], eb);
            word = {bus.usb_dout, word[31:8]};
        end
        check("read_word", word, 32'h34241404);
        check("read_word_count", rd_cnt - r0, 32'd4);

        // Unpopulated block reads zero; back-to-back read from block 1.
        do_read(3'd5, 5'd1, 7'd0, 8'h00);
        do_read(3'd1, 5'd2, 7'd0, 8'h5A);

        // cen low with no strobe asserted: nothing happens.
        w0 = wr_cnt;
        r0 = rd_cnt;
        @(negedge usb_clk);
        bus.usb_cen = 1'b0;
        repeat (2) @(negedge usb_clk);
        bus.usb_cen = 1'b1;
        @(negedge usb_clk);
        check("idle_cen_no_err", {31'b0, bus_err}, 32'h0);
        check("idle_cen_no_strobe", (wr_cnt - w0) + (rd_cnt - r0), 32'd0);

        // Both strobes low: sticky error, no strobe, doe stays low.
        w0 = wr_cnt;
        r0 = rd_cnt;
        bus.usb_addr = mk_addr(3'd0, 5'd0, 7'd0);
        bus.usb_rdn  = 1'b0;
        bus.usb_wrn  = 1'b0;
        @(negedge usb_clk);
        bus.usb_cen = 1'b0;
        repeat (2) @(negedge usb_clk);
        check("err_doe_low", {31'b0, bus.usb_doe}, 32'h0);
        check("err_flag_set", {31'b0, bus_err}, 32'h1);
        bus.usb_cen = 1'b1;
        bus.usb_rdn = 1'b1;
        bus.usb_wrn = 1'b1;
        @(negedge usb_clk);
        check("err_no_strobe", (wr_cnt - w0) + (rd_cnt - r0), 32'd0);
        do_write(3'd0, 5'd1, 7'd0, 8'h11, 1);
        @(negedge usb_clk);
        check("err_sticky", {31'b0, bus_err}, 32'h1);
        resetn = 1'b0;
        #2;
        check("err_cleared_by_reset", {31'b0, bus_err}, 32'h0);
        @(negedge usb_clk);
        resetn = 1'b1;
        @(negedge usb_clk);

        // Reset asserted mid-read, then released with cen still low.
        exp_q.push_back('{is_write: 1'b0, blk: 3'd1, reg_a: 5'd4, bcnt: 7'd0, data: 8'h5A});
        bus.usb_addr = mk_addr(3'd1, 5'd4, 7'd0);
        bus.usb_rdn  = 1'b0;
        @(negedge usb_clk);
        bus.usb_cen = 1'b0;
        @(posedge usb_clk);
        #3;
        resetn = 1'b0;
        #1;
        check("midrst_doe",   {31'b0, bus.usb_doe},  32'h0);
        check("midrst_dout",  {24'b0, bus.usb_dout}, 32'h0);
        check("midrst_read",  {31'b0, reg_read},     32'h0);
        @(negedge usb_clk);
        resetn = 1'b1;
        r0 = rd_cnt;
        repeat (4) @(negedge usb_clk);
        check("postrst_no_strobe", rd_cnt - r0, 32'd0);
        bus.usb_cen = 1'b1;
        bus.usb_rdn = 1'b1;
        @(negedge usb_clk);
        do_read(3'd1, 5'd4, 7'd0, 8'h5A);

        repeat (2) @(negedge usb_clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
